// File: rtl/alu_share_arb_pkg.sv
// Shared types and constants for the alu_share_arb slice: widths, ALU control
// codes and the sequencer state encoding.
package alu_share_arb_pkg;

  localparam int DATA_W  = 32;
  localparam int CTRL_W  = 4;
  localparam int SHAMT_W = 5;

  localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_BEQ  = 4'b0011;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_SLT  = 4'b0111;
  localparam logic [CTRL_W-1:0] ALU_BNE  = 4'b1001;
  localparam logic [CTRL_W-1:0] ALU_LUI  = 4'b1011;
  localparam logic [CTRL_W-1:0] ALU_SRA  = 4'b1110;
  localparam logic [CTRL_W-1:0] ALU_SRAV = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // One-hot client select from a single owner bit (bit 0 = client 0).
  function automatic logic [1:0] owner_onehot(input logic owner);
    return {owner, ~owner};
  endfunction

endpackage

// File: rtl/alu_share_arb_if.sv
// Bundle of request, response and ALU-side signals of alu_share_arb.
// slave = the arbiter itself, master = clients plus the external ALU.
interface alu_share_arb_if;
  import alu_share_arb_pkg::*;

  logic               req0_valid_i;
  logic               req1_valid_i;
  logic               req0_ready_o;
  logic               req1_ready_o;
  logic [DATA_W-1:0]  req0_src1_i;
  logic [DATA_W-1:0]  req0_src2_i;
  logic [DATA_W-1:0]  req1_src1_i;
  logic [DATA_W-1:0]  req1_src2_i;
  logic [CTRL_W-1:0]  req0_ctrl_i;
  logic [CTRL_W-1:0]  req1_ctrl_i;
  logic [SHAMT_W-1:0] req0_shamt_i;
  logic [SHAMT_W-1:0] req1_shamt_i;
  logic               rsp0_valid_o;
  logic               rsp1_valid_o;
  logic               rsp0_ready_i;
  logic               rsp1_ready_i;
  logic [DATA_W-1:0]  rsp_result_o;
  logic               rsp_zero_o;
  logic [DATA_W-1:0]  alu_src1_o;
  logic [DATA_W-1:0]  alu_src2_o;
  logic [CTRL_W-1:0]  alu_ctrl_o;
  logic [SHAMT_W-1:0] alu_shamt_o;
  logic [DATA_W-1:0]  alu_result_i;
  logic               alu_zero_i;

  modport slave (
    input  req0_valid_i, req1_valid_i,
    input  req0_src1_i, req0_src2_i, req1_src1_i, req1_src2_i,
    input  req0_ctrl_i, req1_ctrl_i, req0_shamt_i, req1_shamt_i,
    input  rsp0_ready_i, rsp1_ready_i,
    input  alu_result_i, alu_zero_i,
    output req0_ready_o, req1_ready_o,
    output rsp0_valid_o, rsp1_valid_o, rsp_result_o, rsp_zero_o,
    output alu_src1_o, alu_src2_o, alu_ctrl_o, alu_shamt_o
  );

  modport master (
    output req0_valid_i, req1_valid_i,
    output req0_src1_i, req0_src2_i, req1_src1_i, req1_src2_i,
    output req0_ctrl_i, req1_ctrl_i, req0_shamt_i, req1_shamt_i,
    output rsp0_ready_i, rsp1_ready_i,
    output alu_result_i, alu_zero_i,
    input  req0_ready_o, req1_ready_o,
    input  rsp0_valid_o, rsp1_valid_o, rsp_result_o, rsp_zero_o,
    input  alu_src1_o, alu_src2_o, alu_ctrl_o, alu_shamt_o
  );

endinterface

// File: rtl/alu_share_arb_rr_arb2.sv
// Two-way grant generator. With ALU_SHARE_ARB_RR_EN defined it is round-robin
// with a last-winner pointer; otherwise fixed priority to client 0, no state.
module rr_arb2 (
  input  logic [1:0] req,
  output logic [1:0] grant
`ifdef ALU_SHARE_ARB_RR_EN
  ,
  input  logic       clk,
  input  logic       rst,
  input  logic       update
`endif
);

`ifdef ALU_SHARE_ARB_RR_EN
  logic last_r;

  // Pointer remembers the most recent winner; reset value lets client 0 win the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r <= 1'b1;
    end else if (update) begin
      last_r <= grant[1];
    end else begin
      last_r <= last_r;
    end
  end

  // On a tie the client that did not win last time is served.
  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      if (last_r) begin
        grant = 2'b01;
      end else begin
        grant = 2'b10;
      end
    end else begin
      grant = req;
    end
  end
`else
  // Client 0 always wins; client 1 only when client 0 is idle.
  always_comb begin
    grant = 2'b00;
    if (req[0]) begin
      grant = 2'b01;
    end else begin
      grant = {req[1], 1'b0};
    end
  end
`endif

endmodule

// File: rtl/alu_share_arb.sv
// Arbiter/sequencer sharing one combinational ALU between two clients.
// Optional round-robin arbitration via ALU_SHARE_ARB_RR_EN (fixed priority otherwise).
module alu_share_arb
  import alu_share_arb_pkg::*;
(
  input logic            clk_i,
  input logic            rst_i,
  alu_share_arb_if.slave bus
);

  state_e             state_r;
  state_e             state_nxt_s;
  logic [1:0]         req_s;
  logic [1:0]         grant_s;
  logic [1:0]         ready_s;
  logic [1:0]         rsp_vld_s;
  logic               hs_s;
  logic               rsp_ack_s;
  logic               owner_r;
  logic [DATA_W-1:0]  src1_r;
  logic [DATA_W-1:0]  src2_r;
  logic [CTRL_W-1:0]  ctrl_r;
  logic [SHAMT_W-1:0] shamt_r;
  logic [DATA_W-1:0]  result_r;
  logic               zero_r;

  assign req_s = {bus.req1_valid_i, bus.req0_valid_i};

  rr_arb2 u_arb (
    .req    (req_s),
    .grant  (grant_s)
`ifdef ALU_SHARE_ARB_RR_EN
    ,
    .clk    (clk_i),
    .rst    (rst_i),
    .update (hs_s)
`endif
  );

  // Grant is only offered while idle and out of reset, so at most one ready is high.
  assign ready_s          = (state_r == ST_IDLE && !rst_i) ? grant_s : 2'b00;
  assign hs_s             = |ready_s;
  assign rsp_ack_s        = owner_r ? bus.rsp1_ready_i : bus.rsp0_ready_i;
  assign rsp_vld_s        = (state_r == ST_RESP) ? owner_onehot(owner_r) : 2'b00;

  assign bus.req0_ready_o = ready_s[0];
  assign bus.req1_ready_o = ready_s[1];
  assign bus.rsp0_valid_o = rsp_vld_s[0];
  assign bus.rsp1_valid_o = rsp_vld_s[1];
  assign bus.rsp_result_o = result_r;
  assign bus.rsp_zero_o   = zero_r;
  assign bus.alu_src1_o   = src1_r;
  assign bus.alu_src2_o   = src2_r;
  assign bus.alu_ctrl_o   = ctrl_r;
  assign bus.alu_shamt_o  = shamt_r;

  // Sequencer state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: one op at a time, response must be taken before the next grant.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (hs_s) begin
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_nxt_s = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ack_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Operand register: loads only on handshake so the ALU never sees raw client inputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_r <= 1'b0;
      src1_r  <= '0;
      src2_r  <= '0;
      ctrl_r  <= '0;
      shamt_r <= '0;
    end else if (hs_s) begin
      owner_r <= grant_s[1];
      if (grant_s[1]) begin
        src1_r  <= bus.req1_src1_i;
        src2_r  <= bus.req1_src2_i;
        ctrl_r  <= bus.req1_ctrl_i;
        shamt_r <= bus.req1_shamt_i;
      end else begin
        src1_r  <= bus.req0_src1_i;
        src2_r  <= bus.req0_src2_i;
        ctrl_r  <= bus.req0_ctrl_i;
        shamt_r <= bus.req0_shamt_i;
      end
    end
  end

  // Response register: samples the ALU at the end of EXEC and holds through RESP.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_r <= '0;
      zero_r   <= 1'b0;
    end else if (state_r == ST_EXEC) begin
      result_r <= bus.alu_result_i;
      zero_r   <= bus.alu_zero_i;
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed, table-driven bench for alu_share_arb with a behavioural ALU model.
`timescale 1ns/1ps
module tb_alu_share_arb;
  import alu_share_arb_pkg::*;

  typedef struct {
    int          client;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        z;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   passed;
  logic [31:0] last_src2;
  vec_t vt[11];
  vec_t tmp;

  alu_share_arb_if bus();

  alu_share_arb dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU model
  always_comb begin
    case (bus.alu_ctrl_o)
      ALU_ADD:  bus.alu_result_i = bus.alu_src1_o + bus.alu_src2_o;
      ALU_AND:  bus.alu_result_i = bus.alu_src1_o & bus.alu_src2_o;
      ALU_OR:   bus.alu_result_i = bus.alu_src1_o | bus.alu_src2_o;
      ALU_SLT:  bus.alu_result_i = {31'd0, ($signed(bus.alu_src1_o) < $signed(bus.alu_src2_o))};
      ALU_SRA:  bus.alu_result_i = $signed(bus.alu_src2_o) >>> bus.alu_shamt_o;
      ALU_SRAV: bus.alu_result_i = $signed(bus.alu_src2_o) >>> bus.alu_src1_o[4:0];
      ALU_LUI:  bus.alu_result_i = {bus.alu_src2_o[15:0], 16'h0000};
      default:  bus.alu_result_i = bus.alu_src1_o - bus.alu_src2_o;
    endcase
    bus.alu_zero_i = (bus.alu_result_i == 32'd0);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end else begin
      passed = passed + 1;
    end
  endtask

  function automatic logic rdy(input int c);
    return (c == 1) ? bus.req1_ready_o : bus.req0_ready_o;
  endfunction

  function automatic logic rvld(input int c);
    return (c == 1) ? bus.rsp1_valid_o : bus.rsp0_valid_o;
  endfunction

  task automatic set_req(input int c, input logic v, input vec_t p);
    if (c == 1) begin
      bus.req1_valid_i = v; bus.req1_src1_i = p.a; bus.req1_src2_i = p.b;
      bus.req1_ctrl_i  = p.ctrl; bus.req1_shamt_i = p.sh;
    end else begin
      bus.req0_valid_i = v; bus.req0_src1_i = p.a; bus.req0_src2_i = p.b;
      bus.req0_ctrl_i  = p.ctrl; bus.req0_shamt_i = p.sh;
    end
  endtask

  task automatic set_rsp_ready(input int c, input logic v);
    if (c == 1) bus.rsp1_ready_i = v;
    else        bus.rsp0_ready_i = v;
  endtask

  // One complete operation at minimum latency, with timing and data checks.
  task automatic run_op(input vec_t v, input string nm);
    int n;
    @(negedge clk);
    set_req(v.client, 1'b1, v);
    #1;
    n = 0;
    while (!rdy(v.client) && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk({nm, " handshake"}, {31'd0, rdy(v.client)}, 32'd1);
    chk({nm, " alu held before exec"}, bus.alu_src2_o, last_src2);
    @(negedge clk);
    set_req(v.client, 1'b0, v);
    chk({nm, " exec src1"}, bus.alu_src1_o, v.a);
    chk({nm, " exec src2"}, bus.alu_src2_o, v.b);
    chk({nm, " exec ctrl"}, {28'd0, bus.alu_ctrl_o}, {28'd0, v.ctrl});
    chk({nm, " exec shamt"}, {27'd0, bus.alu_shamt_o}, {27'd0, v.sh});
    chk({nm, " exec no rsp"}, {30'd0, bus.rsp1_valid_o, bus.rsp0_valid_o}, 32'd0);
    @(negedge clk);
    chk({nm, " rsp valid"}, {31'd0, rvld(v.client)}, 32'd1);
    chk({nm, " other rsp"}, {31'd0, rvld(1 - v.client)}, 32'd0);
    chk({nm, " result"}, bus.rsp_result_o, v.res);
    chk({nm, " zero"}, {31'd0, bus.rsp_zero_o}, {31'd0, v.z});
    set_rsp_ready(v.client, 1'b1);
    @(negedge clk);
    set_rsp_ready(v.client, 1'b0);
    chk({nm, " rsp done"}, {31'd0, rvld(v.client)}, 32'd0);
    last_src2 = v.b;
  endtask

  initial begin
    int n;
    logic [1:0] exp_own [4];
    total = 0; passed = 0; last_src2 = 32'd0;
    vt[0]  = '{0, ALU_ADD,  32'd5,        32'd3,        5'd0, 32'd8,        1'b0};
    vt[1]  = '{1, ALU_SRA,  32'd0,        32'h80000000, 5'd4, 32'hF8000000, 1'b0};
    vt[2]  = '{0, ALU_SUB,  32'd7,        32'd7,        5'd0, 32'd0,        1'b1};
    vt[3]  = '{1, ALU_OR,   32'h000000F0, 32'h0000000F, 5'd0, 32'h000000FF, 1'b0};
    vt[4]  = '{0, ALU_AND,  32'hFF00FF00, 32'h0F0F0F0F, 5'd0, 32'h0F000F00, 1'b0};
    vt[5]  = '{1, ALU_SLT,  32'hFFFFFFFF, 32'd1,        5'd0, 32'd1,        1'b0};
    vt[6]  = '{0, ALU_LUI,  32'd0,        32'h00001234, 5'd0, 32'h12340000, 1'b0};
    vt[7]  = '{1, ALU_SRAV, 32'd8,        32'hF0000000, 5'd0, 32'hFFF00000, 1'b0};
    vt[8]  = '{0, ALU_BEQ,  32'd9,        32'd9,        5'd0, 32'd0,        1'b1};
    vt[9]  = '{1, ALU_ADD,  32'hFFFFFFFF, 32'd1,        5'd0, 32'd0,        1'b1};
    vt[10] = '{0, ALU_BNE,  32'd5,        32'd3,        5'd0, 32'd2,        1'b0};
`ifdef ALU_SHARE_ARB_RR_EN
    exp_own = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_own = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif

    // Reset with both clients already requesting the tie case
    rst = 1'b1;
    bus.rsp0_ready_i = 1'b0; bus.rsp1_ready_i = 1'b0;
    tmp = '{0, ALU_SUB, 32'd7, 32'd7, 5'd0, 32'd0, 1'b1};
    set_req(0, 1'b1, tmp);
    tmp = '{1, ALU_OR, 32'h000000F0, 32'h0000000F, 5'd0, 32'h000000FF, 1'b0};
    set_req(1, 1'b1, tmp);
    repeat (3) @(negedge clk);
    chk("reset ready", {30'd0, bus.req1_ready_o, bus.req0_ready_o}, 32'd0);
    chk("reset rsp valid", {30'd0, bus.rsp1_valid_o, bus.rsp0_valid_o}, 32'd0);
    chk("reset result", bus.rsp_result_o, 32'd0);
    chk("reset zero", {31'd0, bus.rsp_zero_o}, 32'd0);
    chk("reset alu src1", bus.alu_src1_o, 32'd0);
    chk("reset alu ctrl", {28'd0, bus.alu_ctrl_o}, 32'd0);

    // First tie after reset goes to client 0 in either arbitration mode
    rst = 1'b0;
    #1;
    chk("tie1 grant", {30'd0, bus.req1_ready_o, bus.req0_ready_o}, 32'd1);
    @(negedge clk);
    bus.req0_valid_i = 1'b0;
    chk("tie1 no accept in exec", {31'd0, bus.req1_ready_o}, 32'd0);
    @(negedge clk);
    chk("tie1 rsp0", {30'd0, bus.rsp1_valid_o, bus.rsp0_valid_o}, 32'd1);
    chk("tie1 result", bus.rsp_result_o, 32'd0);
    chk("tie1 zero", {31'd0, bus.rsp_zero_o}, 32'd1);
    chk("tie1 no accept in resp", {31'd0, bus.req1_ready_o}, 32'd0);
    bus.rsp0_ready_i = 1'b1;
    bus.req0_valid_i = 1'b1;
    @(negedge clk);
    bus.rsp0_ready_i = 1'b0;
    chk("tie1 rsp0 done", {31'd0, bus.rsp0_valid_o}, 32'd0);
`ifdef ALU_SHARE_ARB_RR_EN
    chk("tie2 grant", {30'd0, bus.req1_ready_o, bus.req0_ready_o}, 32'd2);
`else
    chk("tie2 grant", {30'd0, bus.req1_ready_o, bus.req0_ready_o}, 32'd1);
`endif
    bus.req0_valid_i = 1'b0;
    #1;
    chk("c1 grant", {30'd0, bus.req1_ready_o, bus.req0_ready_o}, 32'd2);
    @(negedge clk);
    bus.req1_valid_i = 1'b0;
    @(negedge clk);
    chk("c1 rsp1", {30'd0, bus.rsp1_valid_o, bus.rsp0_valid_o}, 32'd2);
    chk("c1 result", bus.rsp_result_o, 32'h000000FF);
    chk("c1 zero", {31'd0, bus.rsp_zero_o}, 32'd0);
    bus.rsp1_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp1_ready_i = 1'b0;

    // Continuous contention: alternation (RR) or client-0 starvation of client 1 (fixed)
    tmp = '{0, ALU_ADD, 32'd1, 32'd2, 5'd0, 32'd3, 1'b0};
    set_req(0, 1'b1, tmp);
    tmp = '{1, ALU_ADD, 32'd10, 32'd20, 5'd0, 32'd30, 1'b0};
    set_req(1, 1'b1, tmp);
    for (int k = 0; k < 4; k++) begin
      #1;
      n = 0;
      while (!(bus.req0_ready_o || bus.req1_ready_o) && n < 10) begin
        @(negedge clk); #1;
        n++;
      end
      chk($sformatf("contend grant %0d", k), {30'd0, bus.req1_ready_o, bus.req0_ready_o}, {30'd0, exp_own[k]});
      @(negedge clk);
      @(negedge clk);
      chk($sformatf("contend rsp %0d", k), {30'd0, bus.rsp1_valid_o, bus.rsp0_valid_o}, {30'd0, exp_own[k]});
      chk($sformatf("contend result %0d", k), bus.rsp_result_o, exp_own[k][1] ? 32'd30 : 32'd3);
      bus.rsp0_ready_i = 1'b1; bus.rsp1_ready_i = 1'b1;
      @(negedge clk);
      bus.rsp0_ready_i = 1'b0; bus.rsp1_ready_i = 1'b0;
    end
    bus.req0_valid_i = 1'b0; bus.req1_valid_i = 1'b0;
    last_src2 = exp_own[3][1] ? 32'd20 : 32'd2;

    // Back-pressure: response held 4 cycles, accepted on the 5th
    @(negedge clk);
    tmp = '{0, ALU_ADD, 32'd100, 32'd23, 5'd0, 32'd123, 1'b0};
    set_req(0, 1'b1, tmp);
    tmp = '{1, ALU_ADD, 32'd1, 32'd1, 5'd0, 32'd2, 1'b0};
    set_req(1, 1'b1, tmp);
    #1;
    chk("bp grant", {30'd0, bus.req1_ready_o, bus.req0_ready_o}, 32'd1);
    @(negedge clk);
    bus.req0_valid_i = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp rsp0 hold %0d", i), {31'd0, bus.rsp0_valid_o}, 32'd1);
      chk($sformatf("bp result hold %0d", i), bus.rsp_result_o, 32'd123);
      chk($sformatf("bp zero hold %0d", i), {31'd0, bus.rsp_zero_o}, 32'd0);
      chk($sformatf("bp no ready %0d", i), {30'd0, bus.req1_ready_o, bus.req0_ready_o}, 32'd0);
      @(negedge clk);
    end
    chk("bp rsp0 5th", {31'd0, bus.rsp0_valid_o}, 32'd1);
    chk("bp result 5th", bus.rsp_result_o, 32'd123);
    bus.rsp0_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp0_ready_i = 1'b0;
    chk("bp rsp0 done", {31'd0, bus.rsp0_valid_o}, 32'd0);
    chk("bp c1 offered", {31'd0, bus.req1_ready_o}, 32'd1);
    bus.req1_valid_i = 1'b0;
    @(negedge clk);
    chk("withdrawn not granted", bus.alu_src2_o, 32'd23);
    chk("withdrawn no rsp", {30'd0, bus.rsp1_valid_o, bus.rsp0_valid_o}, 32'd0);

    // Reset during EXEC aborts the transaction
    tmp = '{1, ALU_ADD, 32'd1, 32'd1, 5'd0, 32'd2, 1'b0};
    set_req(1, 1'b1, tmp);
    #1;
    chk("abort c1 grant", {31'd0, bus.req1_ready_o}, 32'd1);
    @(negedge clk);
    bus.req1_valid_i = 1'b0;
    rst = 1'b1;
    tmp = '{0, ALU_ADD, 32'd2, 32'd2, 5'd0, 32'd4, 1'b0};
    set_req(0, 1'b1, tmp);
    @(negedge clk);
    chk("abort rsp valid", {30'd0, bus.rsp1_valid_o, bus.rsp0_valid_o}, 32'd0);
    chk("abort ready", {30'd0, bus.req1_ready_o, bus.req0_ready_o}, 32'd0);
    chk("abort alu src1", bus.alu_src1_o, 32'd0);
    chk("abort alu src2", bus.alu_src2_o, 32'd0);
    chk("abort result", bus.rsp_result_o, 32'd0);
    rst = 1'b0;
    #1;
    chk("abort idle ready", {30'd0, bus.req1_ready_o, bus.req0_ready_o}, 32'd1);
    @(negedge clk);
    bus.req0_valid_i = 1'b0;
    chk("abort no stale rsp1", {31'd0, bus.rsp1_valid_o}, 32'd0);
    @(negedge clk);
    chk("post-abort rsp0", {31'd0, bus.rsp0_valid_o}, 32'd1);
    chk("post-abort result", bus.rsp_result_o, 32'd4);
    bus.rsp0_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp0_ready_i = 1'b0;
    last_src2 = 32'd2;

    // Table of single-client operations
    for (int i = 0; i < 11; i++) begin
      run_op(vt[i], $sformatf("vec%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
